// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side scheduler.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_LEN  = 4;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit after last_owner, wrapping around.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_owner,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester after last_owner wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(last_owner) + i) % N);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing the async FIFO write port among NUM_REQ requesters.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among pending requests (one cycle)
//   BURST | owner writes up to BURST_LEN words; stalls while full
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          wr_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  arb_state_t    state;
  logic [IW-1:0] last_owner;
  logic [BW-1:0] burst_cnt;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          owner_req;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  assign owner_req = req[owner];
  assign busy      = (state == BURST);
  assign wr_en     = busy & owner_req & ~full;

  always_comb begin
    gnt     = '0;
    data_in = '0;
    if (wr_en) begin
      gnt[owner] = 1'b1;
      data_in    = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      wr_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (!owner_req) begin
            state      <= IDLE;
            last_owner <= owner;
          end else if (!full) begin
            wr_count <= wr_count + CNT_WIDTH'(1);
            if (burst_cnt == LAST_BEAT) begin
              state      <= IDLE;
              last_owner <= owner;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end
          // full with the owner still requesting: hold ownership and beat count
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus queues expected writes, a negedge monitor checks them.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic             full;

  logic [NR-1:0]    gnt;
  logic             wr_en;
  logic [DW-1:0]    data_in;
  logic [1:0]       owner;
  logic             busy;
  logic [15:0]      wr_count;

  logic [NR-1:0]    gnt_w;
  logic             wr_en_w;
  logic [DW-1:0]    data_in_w;
  logic [1:0]       owner_w;
  logic             busy_w;
  logic [3:0]       wr_count_w;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .wr_en(wr_en), .data_in(data_in), .owner(owner), .busy(busy),
    .wr_count(wr_count)
  );

  // Narrow-counter copy on the same inputs, used for the wrap check.
  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt_w), .wr_en(wr_en_w), .data_in(data_in_w), .owner(owner_w), .busy(busy_w),
    .wr_count(wr_count_w)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [DW-1:0] data;
    logic [15:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [DW-1:0] slice_val(input int o);
    return 8'(32'hA0 + 32'h11 * o);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push_burst(input int o, input int n, input int start);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.gnt  = NR'(1 << o);
      e.data = slice_val(o);
      e.cnt  = 16'(start + k);
      sb.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    chk("drain_before_reset", 32'(sb.size()), 0);
    rst_n = 1'b0;
    #1;
    chk("reset_wr_count", 32'(wr_count), 0);
    tick(1);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (wr_en || gnt != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(gnt) | 32'(wr_en), 0);
      end else begin
        e = sb.pop_front();
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("data_in", 32'(data_in), 32'(e.data));
        chk("wr_count_pre", 32'(wr_count), 32'(e.cnt));
        chk("wr_en_while_full", 32'(full), 0);
      end
    end else begin
      chk("idle_data_in", 32'(data_in), 0);
    end
  end

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    full     = 1'b0;
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_data_in", 32'(data_in), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single requester: 1 idle + 4 writes, twice
    push_burst(1, 4, 0);
    push_burst(1, 4, 4);
    req = 4'b0010;
    tick(1);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_owner", 32'(owner), 1);
    chk("s1_gnt", 32'(gnt), 32'h2);
    tick(4);
    chk("s1_gap_busy", 32'(busy), 0);
    chk("s1_gap_wr_en", 32'(wr_en), 0);
    chk("s1_gap_count", 32'(wr_count), 4);
    tick(5);
    chk("s1_end_count", 32'(wr_count), 8);
    chk("s1_end_busy", 32'(busy), 0);
    req = '0;
    tick(2);
    chk("s1_drain", 32'(sb.size()), 0);

    // contention 0 and 2 after reset
    reset_dut();
    push_burst(0, 4, 0);
    push_burst(2, 4, 4);
    push_burst(0, 4, 8);
    push_burst(2, 4, 12);
    req = 4'b0101;
    tick(1);
    chk("s2_owner0", 32'(owner), 0);
    tick(5);
    chk("s2_owner2", 32'(owner), 2);
    chk("s2_busy", 32'(busy), 1);
    tick(14);
    chk("s2_count", 32'(wr_count), 16);
    chk("s2_busy_end", 32'(busy), 0);
    req = '0;
    tick(2);
    chk("s2_drain", 32'(sb.size()), 0);

    // full stall at burst_cnt=2
    push_burst(0, 4, 16);
    req = 4'b0001;
    tick(3);
    full = 1'b1;
    #1;
    chk("s3_stall_wr_en", 32'(wr_en), 0);
    chk("s3_stall_gnt", 32'(gnt), 0);
    chk("s3_stall_busy", 32'(busy), 1);
    chk("s3_stall_count", 32'(wr_count), 18);
    tick(3);
    chk("s3_held_count", 32'(wr_count), 18);
    chk("s3_held_busy", 32'(busy), 1);
    chk("s3_held_owner", 32'(owner), 0);
    full = 1'b0;
    tick(1);
    chk("s3_resume_busy", 32'(busy), 1);
    tick(1);
    chk("s3_done_busy", 32'(busy), 0);
    chk("s3_done_count", 32'(wr_count), 20);
    req = '0;
    tick(2);
    chk("s3_drain", 32'(sb.size()), 0);

    // early release by requester 3, then fairness
    push_burst(3, 2, 20);
    push_burst(0, 4, 22);
    push_burst(3, 4, 26);
    req = 4'b1000;
    tick(1);
    chk("s4_owner3", 32'(owner), 3);
    tick(2);
    req = 4'b0001;
    #1;
    chk("s4_release_wr_en", 32'(wr_en), 0);
    chk("s4_release_busy", 32'(busy), 1);
    tick(1);
    chk("s4_idle_busy", 32'(busy), 0);
    chk("s4_idle_count", 32'(wr_count), 22);
    req = 4'b1001;
    tick(1);
    chk("s4_next_owner", 32'(owner), 0);
    chk("s4_next_busy", 32'(busy), 1);
    tick(5);
    chk("s4_fair_owner", 32'(owner), 3);
    tick(4);
    chk("s4_count", 32'(wr_count), 30);
    chk("s4_busy_end", 32'(busy), 0);
    req = '0;
    tick(2);
    chk("s4_drain", 32'(sb.size()), 0);

    // reset mid-burst
    push_burst(0, 1, 30);
    req = 4'b1111;
    tick(1);
    chk("s5_owner", 32'(owner), 0);
    tick(1);
    chk("s5_drain_pre", 32'(sb.size()), 0);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_gnt", 32'(gnt), 0);
    chk("s5_rst_wr_en", 32'(wr_en), 0);
    chk("s5_rst_busy", 32'(busy), 0);
    chk("s5_rst_count", 32'(wr_count), 0);
    chk("s5_rst_owner", 32'(owner), 0);
    chk("s5_rst_data", 32'(data_in), 0);
    tick(1);
    rst_n = 1'b1;
    push_burst(0, 4, 0);
    tick(1);
    chk("s5_first_owner", 32'(owner), 0);
    chk("s5_first_busy", 32'(busy), 1);
    tick(4);
    chk("s5_busy_end", 32'(busy), 0);
    chk("s5_count", 32'(wr_count), 4);
    req = '0;
    tick(2);
    chk("s5_drain", 32'(sb.size()), 0);

    // counter wrap on the 4-bit copy: 17 writes
    reset_dut();
    push_burst(0, 4, 0);
    push_burst(0, 4, 4);
    push_burst(0, 4, 8);
    push_burst(0, 4, 12);
    push_burst(0, 1, 16);
    req = 4'b0001;
    tick(20);
    chk("s6_count16", 32'(wr_count), 16);
    chk("s6_wrap0", 32'(wr_count_w), 0);
    tick(2);
    req = '0;
    tick(1);
    chk("s6_busy_end", 32'(busy), 0);
    chk("s6_count17", 32'(wr_count), 17);
    chk("s6_wrap1", 32'(wr_count_w), 1);
    tick(2);
    chk("s6_drain", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
